// File: rtl/match_controller_pkg.sv
// match_pkg: shared state encoding, winner codes and wicket limit for match_controller.
package match_pkg;

  typedef enum logic [3:0] {
    INN1_READY,
    INN1_FIRE,
    INN1_SETTLE,
    INN1_CHECK,
    BREAK,
    INN2_READY,
    INN2_FIRE,
    INN2_SETTLE,
    INN2_CHECK,
    DONE
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_T1   = 2'b01;
  localparam logic [1:0] WIN_T2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [3:0] ALL_OUT = 4'd10;

endpackage

// File: rtl/match_controller_over_counter.sv
// over_counter: ball/over tally for one innings, with a look-ahead flag raised on
// the strobe that completes the final over.
module over_counter #(
  parameter int MAX_OVERS      = 2,
  parameter int BALLS_PER_OVER = 6
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       clear,
  input  logic       ball_strobe,
  output logic [2:0] ball_count,
  output logic [3:0] over_count,
  output logic       overs_done
);

  localparam logic [2:0] LAST_BALL = 3'(BALLS_PER_OVER - 1);
  localparam logic [3:0] LAST_OVER = 4'(MAX_OVERS - 1);

  logic [2:0] ball_q, ball_d;
  logic [3:0] over_q, over_d;

  always_comb begin
    ball_d     = ball_q;
    over_d     = over_q;
    overs_done = 1'b0;
    if (clear) begin
      ball_d = '0;
      over_d = '0;
    end else if (ball_strobe) begin
      if (ball_q == LAST_BALL) begin
        ball_d     = '0;
        over_d     = over_q + 4'd1;
        // Combinational so the caller can end the innings on this same strobe.
        overs_done = (over_q == LAST_OVER);
      end else begin
        ball_d = ball_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      ball_q <= '0;
      over_q <= '0;
    end else begin
      ball_q <= ball_d;
      over_q <= over_d;
    end
  end

  assign ball_count = ball_q;
  assign over_count = over_q;

endmodule

// File: rtl/match_controller.sv
// match_controller: sequences deliveries, innings changeover, chase target and result.
// Define MATCH_BREAK_HOLD_EN to hold the innings break until a bowl request arrives.
module match_controller #(
  parameter int MAX_OVERS      = 2,
  parameter int BALLS_PER_OVER = 6,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       bowl_req,
  input  logic [7:0] runs_in,
  input  logic [3:0] wickets_in,
  output logic       delivery,
  output logic       teamSwitch,
  output logic       gameOver,
  output logic [2:0] ball_count,
  output logic [3:0] over_count,
  output logic [8:0] target,
  output logic [1:0] winner
);
  import match_pkg::*;

  localparam logic [7:0] LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [8:0] target_q, target_d;
  logic [1:0] winner_q, winner_d;
  logic       team_switch_q, team_switch_d;
  logic       game_over_q, game_over_d;

  logic       ball_strobe, cnt_clear, overs_done, all_out;
  logic [8:0] runs_ext;

  assign runs_ext = {1'b0, runs_in};
  assign all_out  = (wickets_in == ALL_OUT);

  over_counter #(
    .MAX_OVERS      (MAX_OVERS),
    .BALLS_PER_OVER (BALLS_PER_OVER)
  ) u_over_counter (
    .clk_fpga    (clk_fpga),
    .reset       (reset),
    .clear       (cnt_clear),
    .ball_strobe (ball_strobe),
    .ball_count  (ball_count),
    .over_count  (over_count),
    .overs_done  (overs_done)
  );

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    target_d      = target_q;
    winner_d      = winner_q;
    team_switch_d = team_switch_q;
    game_over_d   = game_over_q;
    ball_strobe   = 1'b0;
    cnt_clear     = 1'b0;
    case (state_q)
      INN1_READY:  if (bowl_req) state_d = INN1_FIRE;
      INN1_FIRE: begin
        settle_d = '0;
        state_d  = INN1_SETTLE;
      end
      INN1_SETTLE: begin
        if (settle_q == LAST_SETTLE) state_d = INN1_CHECK;
        else settle_d = settle_q + 8'd1;
      end
      INN1_CHECK: begin
        ball_strobe = 1'b1;
        if (all_out || overs_done) begin
          target_d      = runs_ext + 9'd1;
          team_switch_d = 1'b1;
          state_d       = BREAK;
        end else begin
          state_d = INN1_READY;
        end
      end
      BREAK: begin
        cnt_clear = 1'b1;
`ifdef MATCH_BREAK_HOLD_EN
        if (bowl_req) state_d = INN2_READY;
`else
        state_d = INN2_READY;
`endif
      end
      INN2_READY:  if (bowl_req) state_d = INN2_FIRE;
      INN2_FIRE: begin
        settle_d = '0;
        state_d  = INN2_SETTLE;
      end
      INN2_SETTLE: begin
        if (settle_q == LAST_SETTLE) state_d = INN2_CHECK;
        else settle_d = settle_q + 8'd1;
      end
      INN2_CHECK: begin
        ball_strobe = 1'b1;
        // Reaching the target outranks an innings that ends on the same ball.
        if (runs_ext >= target_q) begin
          winner_d    = WIN_T2;
          game_over_d = 1'b1;
          state_d     = DONE;
        end else if (all_out || overs_done) begin
          winner_d    = (runs_ext < target_q - 9'd1) ? WIN_T1 : WIN_TIE;
          game_over_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = INN2_READY;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = INN1_READY;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q       <= INN1_READY;
      settle_q      <= '0;
      target_q      <= '0;
      winner_q      <= WIN_NONE;
      team_switch_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      target_q      <= target_d;
      winner_q      <= winner_d;
      team_switch_q <= team_switch_d;
      game_over_q   <= game_over_d;
    end
  end

  assign delivery   = (state_q == INN1_FIRE) || (state_q == INN2_FIRE);
  assign teamSwitch = team_switch_q;
  assign gameOver   = game_over_q;
  assign target     = target_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller (default parameters, break not held).
module tb_match_controller;

  localparam int S = 2;

  logic       clk_fpga = 1'b0;
  logic       reset;
  logic       bowl_req;
  logic [7:0] runs_in;
  logic [3:0] wickets_in;
  logic       delivery, teamSwitch, gameOver;
  logic [2:0] ball_count;
  logic [3:0] over_count;
  logic [8:0] target;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_fpga = ~clk_fpga;

  match_controller #(
    .MAX_OVERS      (2),
    .BALLS_PER_OVER (6),
    .SETTLE_CYCLES  (S)
  ) dut (
    .clk_fpga   (clk_fpga),
    .reset      (reset),
    .bowl_req   (bowl_req),
    .runs_in    (runs_in),
    .wickets_in (wickets_in),
    .delivery   (delivery),
    .teamSwitch (teamSwitch),
    .gameOver   (gameOver),
    .ball_count (ball_count),
    .over_count (over_count),
    .target     (target),
    .winner     (winner)
  );

  typedef struct {
    int runs;
    int wkts;
    int e_ball;
    int e_over;
    int e_team;
    int e_target;
    int e_winner;
    int e_go;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(int r, int w, int b, int o, int t, int tg, int wn, int go);
    vec_t v;
    v.runs = r; v.wkts = w; v.e_ball = b; v.e_over = o;
    v.e_team = t; v.e_target = tg; v.e_winner = wn; v.e_go = go;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic check_outs(input string name, input int b, input int o, input int t,
                            input int tg, input int wn, input int go);
    chk({name, ".ball_count"}, int'(ball_count), b);
    chk({name, ".over_count"}, int'(over_count), o);
    chk({name, ".teamSwitch"}, int'(teamSwitch), t);
    chk({name, ".target"},     int'(target),     tg);
    chk({name, ".winner"},     int'(winner),     wn);
    chk({name, ".gameOver"},   int'(gameOver),   go);
  endtask

  task automatic do_reset();
    bowl_req   = 1'b0;
    runs_in    = '0;
    wickets_in = '0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One idle cycle (lets a one-cycle break elapse), then a request, then run to the
  // cycle after CHECK.
  task automatic bowl(input int r, input int w);
    tick();
    runs_in    = 8'(r);
    wickets_in = 4'(w);
    bowl_req   = 1'b1;
    tick();
    bowl_req = 1'b0;
    repeat (S + 2) tick();
  endtask

  task automatic play_innings1(input int r);
    for (int i = 0; i < 12; i++) bowl(r, 0);
  endtask

  initial begin
    int d;

    vecs[0]  = mk(20, 0, 1, 0, 0,  0, 0, 0);
    vecs[1]  = mk(20, 0, 2, 0, 0,  0, 0, 0);
    vecs[2]  = mk(20, 0, 3, 0, 0,  0, 0, 0);
    vecs[3]  = mk(20, 0, 4, 0, 0,  0, 0, 0);
    vecs[4]  = mk(20, 0, 5, 0, 0,  0, 0, 0);
    vecs[5]  = mk(20, 0, 0, 1, 0,  0, 0, 0);
    vecs[6]  = mk(20, 0, 1, 1, 0,  0, 0, 0);
    vecs[7]  = mk(20, 0, 2, 1, 0,  0, 0, 0);
    vecs[8]  = mk(20, 0, 3, 1, 0,  0, 0, 0);
    vecs[9]  = mk(20, 0, 4, 1, 0,  0, 0, 0);
    vecs[10] = mk(20, 0, 5, 1, 0,  0, 0, 0);
    vecs[11] = mk(20, 0, 0, 2, 1, 21, 0, 0);
    vecs[12] = mk(4,  0, 1, 0, 1, 21, 0, 0);
    vecs[13] = mk(10, 1, 2, 0, 1, 21, 0, 0);
    vecs[14] = mk(21, 1, 3, 0, 1, 21, 2, 1);

    // Reset state and first-ball latency.
    do_reset();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.delivery", int'(delivery), 0);
    bowl_req = 1'b1;
    tick();
    bowl_req = 1'b0;
    chk("lat.delivery_n1", int'(delivery), 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("lat.delivery_n%0d", i), int'(delivery), 0);
      chk($sformatf("lat.ball_n%0d", i), int'(ball_count), 0);
    end
    tick();
    chk("lat.ball_n5", int'(ball_count), 1);
    chk("lat.delivery_n5", int'(delivery), 0);

    // Full innings 1 then a chase that succeeds on ball 3.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bowl(vecs[i].runs, vecs[i].wkts);
      check_outs($sformatf("vec%0d", i), vecs[i].e_ball, vecs[i].e_over, vecs[i].e_team,
                 vecs[i].e_target, vecs[i].e_winner, vecs[i].e_go);
      if (i == 11) begin
        tick();
        chk("inn2_start.ball_count", int'(ball_count), 0);
        chk("inn2_start.over_count", int'(over_count), 0);
        chk("inn2_start.teamSwitch", int'(teamSwitch), 1);
      end
    end
    d = 0;
    for (int i = 0; i < 20; i++) begin
      bowl_req = (i % 4 == 0);
      tick();
      d += int'(delivery);
    end
    bowl_req = 1'b0;
    chk("done.no_delivery", d, 0);
    chk("done.gameOver_held", int'(gameOver), 1);
    chk("done.winner_held", int'(winner), 2);

    // All out on the ball that also completes an over; runs 255 gives target 256.
    do_reset();
    for (int i = 0; i < 5; i++) bowl(30, 3);
    bowl(255, 10);
    check_outs("allout", 0, 1, 1, 256, 0, 0);
    tick();
    chk("allout.cleared_ball", int'(ball_count), 0);
    chk("allout.cleared_over", int'(over_count), 0);

    // Overs exhausted in innings 2: tie, then team 1 wins.
    do_reset();
    play_innings1(20);
    for (int i = 0; i < 11; i++) bowl(10, 2);
    bowl(20, 2);
    check_outs("tie", 0, 2, 1, 21, 3, 1);

    do_reset();
    play_innings1(20);
    for (int i = 0; i < 11; i++) bowl(10, 2);
    bowl(15, 2);
    check_outs("t1win", 0, 2, 1, 21, 1, 1);

    // Team 2 all out short of the target.
    do_reset();
    play_innings1(20);
    for (int i = 0; i < 3; i++) bowl(12, 5);
    bowl(19, 10);
    check_outs("inn2_allout", 4, 0, 1, 21, 1, 1);

    // Requests during FIRE/SETTLE/CHECK are dropped.
    do_reset();
    bowl_req = 1'b1;
    tick();
    d = int'(delivery);
    for (int i = 0; i < 3; i++) begin
      bowl_req = 1'b1;
      tick();
      d += int'(delivery);
    end
    bowl_req = 1'b0;
    repeat (6) begin
      tick();
      d += int'(delivery);
    end
    chk("settle_req.deliveries", d, 1);
    chk("settle_req.ball_count", int'(ball_count), 1);

    // Reset while delivery is high.
    bowl_req = 1'b1;
    tick();
    bowl_req = 1'b0;
    chk("rst_fire.pre_delivery", int'(delivery), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_fire.delivery", int'(delivery), 0);
    check_outs("rst_fire", 0, 0, 0, 0, 0, 0);
    d = 0;
    repeat (6) begin
      tick();
      d += int'(delivery);
    end
    chk("rst_fire.no_late_delivery", d, 0);
    chk("rst_fire.ball_stays", int'(ball_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
